// File: rtl/btle_pkg.sv
// Shared constants and helpers for the BTLE receive framer.
// Holds the FSM encoding, CRC/whitening polynomials and channel map.
package btle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH_AA,
        ST_RX_HEADER,
        ST_RX_PAYLOAD,
        ST_RX_CRC,
        ST_DONE
    } state_t;

    localparam logic [23:0] CRC_POLY = 24'h00065B;

    // x^7 + x^4 + 1, stored with the register's bit 6 as stage 0,
    // so the x^4 tap lands on bit 2 of the rotated value.
    localparam logic [6:0] WHITEN_TAP = 7'b000_0100;

    localparam int ADV_CH_37 = 37;
    localparam int ADV_CH_38 = 38;
    localparam int ADV_CH_39 = 39;

    localparam int PDU_MEM_DEPTH = 64;

    // One whitening step: rotate toward bit 0, fold the output into the tap.
    function automatic logic [6:0] whiten_step(input logic [6:0] s);
        return {s[0], s[6:1]} ^ ({7{s[0]}} & WHITEN_TAP);
    endfunction

endpackage

// File: rtl/btle_aa_correlator.sv
// Access-address correlator: 32-bit search shift register,
// popcount of the mismatch against the expected AA, threshold compare.
module btle_aa_correlator
    import btle_pkg::*;
#(
    parameter int MAX_BIT_ERR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_shift,
    input  logic        i_bit,
    input  logic [31:0] i_aa,
    output logic        o_match
);

    logic [31:0] r_sr;
    logic [31:0] w_next;
    logic [31:0] w_diff;
    logic [5:0]  w_pop;

    assign w_next = {i_bit, r_sr[31:1]};
    assign w_diff = w_next ^ i_aa;

    // Count mismatching bits of the register as it will be after this shift.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < 32; i++) begin
            w_pop = w_pop + 6'(w_diff[i]);
        end
    end

    assign o_match = i_shift && (int'(w_pop) <= MAX_BIT_ERR);

    // Search register: cleared whenever not searching, shifts right on valid bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sr <= '0;
        end else if (i_clear) begin
            r_sr <= '0;
        end else if (i_shift) begin
            r_sr <= w_next;
        end
    end

endmodule

// File: rtl/btle_rx_framer.sv
// BTLE receive framer: access-address search, de-whitening, CRC24
// check and PDU octet writes into a 64-entry memory.
module btle_rx_framer
    import btle_pkg::*;
#(
    parameter int CRC_STATE_BIT_WIDTH      = 24,
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int AA_MAX_BIT_ERR           = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rx_enable,
    input  logic [31:0]                         access_address,
    input  logic [CRC_STATE_BIT_WIDTH-1:0]      crc_state_init_bit,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    input  logic                                phy_bit,
    input  logic                                phy_bit_valid,
    output logic [5:0]                          pdu_octet_mem_addr,
    output logic [7:0]                          pdu_octet_mem_data,
    output logic                                pdu_octet_mem_we,
    output logic                                aa_hit,
    output logic [6:0]                          payload_length,
    output logic                                rx_done,
    output logic                                crc_ok,
    output logic                                busy
);

    localparam int CW    = CRC_STATE_BIT_WIDTH;
    localparam int CNT_W = $clog2(CW);

    state_t           r_state;
    logic [CW-1:0]    r_crc;
    logic [6:0]       r_lfsr;
    logic [7:0]       r_oct;
    logic [2:0]       r_bit_cnt;
    logic [6:0]       r_oct_idx;
    logic [CNT_W-1:0] r_crc_cnt;
    logic             r_crc_err;
    logic [5:0]       r_mem_addr;
    logic [7:0]       r_mem_data;
    logic             r_mem_we;
    logic             r_aa_hit;
    logic [6:0]       r_len;
    logic             r_rx_done;
    logic             r_crc_ok;

    logic             w_aa_match;
    logic             w_d;
    logic [7:0]       w_octet;
    logic             w_last_bit;
    logic             w_crc_fb;
    logic [CW-1:0]    w_crc_next;
    logic             w_crc_miss;
    logic             w_adv;
    logic [6:0]       w_len;

    btle_aa_correlator #(
        .MAX_BIT_ERR(AA_MAX_BIT_ERR)
    ) u_corr (
        .clk    (clk),
        .rst    (rst),
        .i_clear(r_state != ST_SEARCH_AA),
        .i_shift(r_state == ST_SEARCH_AA && phy_bit_valid),
        .i_bit  (phy_bit),
        .i_aa   (access_address),
        .o_match(w_aa_match)
    );

    assign w_d        = phy_bit ^ r_lfsr[0];
    assign w_octet    = {w_d, r_oct[7:1]};
    assign w_last_bit = (r_bit_cnt == 3'd7);
    assign w_crc_fb   = r_crc[CW-1] ^ w_d;
    assign w_crc_next = {r_crc[CW-2:0], 1'b0}
                      ^ (w_crc_fb ? CW'(CRC_POLY) : '0);
    assign w_crc_miss = w_d ^ r_crc[CW-1];

    assign w_adv = (channel_number == CHANNEL_NUMBER_BIT_WIDTH'(ADV_CH_37))
                || (channel_number == CHANNEL_NUMBER_BIT_WIDTH'(ADV_CH_38))
                || (channel_number == CHANNEL_NUMBER_BIT_WIDTH'(ADV_CH_39));
    assign w_len = w_adv ? {1'b0, w_octet[5:0]} : {2'b0, w_octet[4:0]};

    // Receive FSM with datapath; an rx_enable drop overrides everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_crc      <= '0;
            r_lfsr     <= '0;
            r_oct      <= '0;
            r_bit_cnt  <= '0;
            r_oct_idx  <= '0;
            r_crc_cnt  <= '0;
            r_crc_err  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_we   <= 1'b0;
            r_aa_hit   <= 1'b0;
            r_len      <= '0;
            r_rx_done  <= 1'b0;
            r_crc_ok   <= 1'b0;
        end else begin
            r_mem_we  <= 1'b0;
            r_aa_hit  <= 1'b0;
            r_rx_done <= 1'b0;
            if (!rx_enable) begin
                r_state <= ST_IDLE;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_SEARCH_AA;
                    end
                    ST_SEARCH_AA: begin
                        if (w_aa_match) begin
                            r_aa_hit  <= 1'b1;
                            r_crc     <= crc_state_init_bit;
                            r_lfsr    <= {1'b1, channel_number[5:0]};
                            r_bit_cnt <= '0;
                            r_oct_idx <= '0;
                            r_crc_cnt <= '0;
                            r_crc_err <= 1'b0;
                            r_state   <= ST_RX_HEADER;
                        end
                    end
                    ST_RX_HEADER, ST_RX_PAYLOAD: begin
                        if (phy_bit_valid) begin
                            r_crc     <= w_crc_next;
                            r_lfsr    <= whiten_step(r_lfsr);
                            r_oct     <= w_octet;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                r_mem_we   <= (r_oct_idx < 7'(PDU_MEM_DEPTH));
                                r_mem_addr <= r_oct_idx[5:0];
                                r_mem_data <= w_octet;
                                r_oct_idx  <= r_oct_idx + 7'd1;
                                if (r_state == ST_RX_HEADER && r_oct_idx == 7'd1) begin
                                    r_len   <= w_len;
                                    r_state <= (w_len == '0) ? ST_RX_CRC : ST_RX_PAYLOAD;
                                end else if (r_state == ST_RX_PAYLOAD
                                             && r_oct_idx == r_len + 7'd1) begin
                                    r_state <= ST_RX_CRC;
                                end
                            end
                        end
                    end
                    ST_RX_CRC: begin
                        if (phy_bit_valid) begin
                            r_lfsr    <= whiten_step(r_lfsr);
                            r_crc     <= r_crc << 1;
                            r_crc_cnt <= r_crc_cnt + 1'b1;
                            if (w_crc_miss) begin
                                r_crc_err <= 1'b1;
                            end
                            if (r_crc_cnt == CNT_W'(CW - 1)) begin
                                r_state   <= ST_DONE;
                                r_rx_done <= 1'b1;
                                r_crc_ok  <= !(r_crc_err || w_crc_miss);
                            end
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_SEARCH_AA;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign pdu_octet_mem_addr = r_mem_addr;
    assign pdu_octet_mem_data = r_mem_data;
    assign pdu_octet_mem_we   = r_mem_we;
    assign aa_hit             = r_aa_hit;
    assign payload_length     = r_len;
    assign rx_done            = r_rx_done;
    assign crc_ok             = r_crc_ok;
    assign busy               = (r_state != ST_IDLE) && (r_state != ST_SEARCH_AA);

endmodule

// File: doc/btle_rx_framer.md
BTLE_RX_FRAMER -- requirements
Module: btle_rx_framer

Interface
REQ-001 SHALL have parameter CRC_STATE_BIT_WIDTH, default 24, CRC register width.
REQ-002 SHALL have parameter CHANNEL_NUMBER_BIT_WIDTH, default 6, channel number width.
REQ-003 SHALL have parameter AA_MAX_BIT_ERR, default 0, maximum Hamming distance accepted on the access address.
REQ-004 One clock; reset is synchronous and active-low. Ports: clk  in  1  clock; rst  in  1  synchronous active-low reset (rst==0 resets).
REQ-005 SHALL have these inputs:
- rx_enable  in  1  enables the search and receive functions.
- access_address  in  32  expected access address, LSB received first.
- crc_state_init_bit  in  CRC_STATE_BIT_WIDTH  CRC initial state.
- channel_number  in  CHANNEL_NUMBER_BIT_WIDTH  whitening seed; 37/38/39 are advertising channels.
- phy_bit, phy_bit_valid  in  1 each  demodulated bit stream, one bit per valid cycle.
REQ-006 SHALL have these outputs:
- pdu_octet_mem_addr  out  6  write address.
- pdu_octet_mem_data  out  8  write data.
- pdu_octet_mem_we  out  1  write strobe.
- aa_hit  out  1  one-cycle pulse on access address match.
- payload_length  out  7  decoded payload length.
- rx_done  out  1  one-cycle pulse at end of packet.
- crc_ok  out  1  CRC result, valid from rx_done.
- busy  out  1  high outside IDLE and SEARCH_AA.

Function
REQ-007 States SHALL be IDLE, SEARCH_AA, RX_HEADER, RX_PAYLOAD, RX_CRC, DONE; all state advances and shifts SHALL occur only on phy_bit_valid cycles, except DONE and aborts.
REQ-008 IDLE -> SEARCH_AA when rx_enable==1.
REQ-009 In SEARCH_AA, each valid bit SHALL shift into a 32-bit register (new bit enters bit 31, the register shifts right).
REQ-010 On the first valid bit after which popcount(register ^ access_address) <= AA_MAX_BIT_ERR, the block SHALL:
- pulse aa_hit the next cycle;
- load the CRC state with crc_state_init_bit;
- load the 7-bit whitening LFSR with {1'b1, channel_number[5:0]};
- reset the octet and bit counters;
- go to RX_HEADER.
REQ-011 The search register SHALL clear on entry to SEARCH_AA, so no match can use stale bits from a previous packet.
REQ-012 Every post-AA bit SHALL be de-whitened as d = phy_bit ^ lfsr output. The LFSR uses x^7+x^4+1 and steps with the same convention as the TX scramble core.
REQ-013 In RX_HEADER and RX_PAYLOAD, d SHALL feed the CRC as fb = state[23]^d; state = {state[22:0],1'b0} ^ (fb ? 24'h00065B : 0). This matches the TX crc24 core.
REQ-014 De-whitened bits SHALL assemble LSB-first into octets. On the cycle after an octet's 8th bit, the block SHALL write it at pdu_octet_mem_addr = octet index, with pdu_octet_mem_we high for 1 cycle.
REQ-015 After 16 header bits, payload_length SHALL become {1'b0,octet1[5:0]} if channel_number is 37, 38 or 39, else {2'b0,octet1[4:0]}.
- If the length is 0 -> RX_CRC.
- Otherwise -> RX_PAYLOAD for payload_length*8 bits, then RX_CRC.
REQ-016 Octet indices >= 64 (adv length 63 gives 65 octets) SHALL NOT be written. The CRC SHALL still cover them.
REQ-017 RX_CRC SHALL compare 24 de-whitened bits in order against the frozen CRC state bits 23 down to 0.
- crc_ok = 1 iff all 24 bits match.
- CRC bits SHALL NOT be written to memory.
REQ-018 After the 24th CRC bit the block SHALL go to DONE.
- rx_done pulses 1 cycle in DONE.
- crc_ok updates in the same cycle and holds until the next rx_done.
- DONE -> SEARCH_AA if rx_enable, else IDLE.
REQ-019 rx_enable==0 in any state SHALL abort to IDLE on the next cycle.
- No rx_done is produced.
- No further writes occur.
- payload_length and crc_ok are held.
REQ-020 phy_bit_valid during DONE SHALL be ignored.

Reset
REQ-021 rst==0 SHALL force IDLE and set to 0: all outputs, payload_length, crc_ok, and the search, CRC and LFSR registers. This applies mid-packet too; no write or rx_done follows.

Structure
REQ-022 A shared package btle_pkg SHALL hold:
- the state encoding;
- CRC polynomial 24'h00065B;
- the whitening polynomial;
- the advertising channel numbers 37/38/39;
- the PDU memory depth 64.
REQ-023 The Hamming-distance comparator SHALL be one sub-module, btle_aa_correlator (32-bit register, popcount, threshold compare).

Verification
REQ-024 Loopback through btle_tx phy_bit with AA 0x8E89BED6, channel 37, CRC init 0x555555, payload length 6 SHALL produce:
- aa_hit once;
- 8 writes (addr 0..7) equal to the TX PDU;
- payload_length 6;
- rx_done with crc_ok=1.
REQ-025 The same packet with one CRC bit flipped SHALL give rx_done with crc_ok=0 and the same 8 memory writes.
REQ-026 AA with 1 bit flipped: AA_MAX_BIT_ERR=0 -> no aa_hit or rx_done; AA_MAX_BIT_ERR=1 -> aa_hit and crc_ok=1.
REQ-027 Channel 37, length 63 SHALL produce 64 writes (addr 0..63), no 65th write, and crc_ok=1. On channel 10 with header byte 0x3F, payload_length SHALL be 31.
REQ-028 rx_enable dropped at payload bit 20, or rst low mid-payload, SHALL give:
- IDLE next cycle, no rx_done;
- with rx_enable re-asserted, a correct receive of the following packet.
